// File: rtl/alu_seq_pkg.sv
// Shared opcode, flag-index, engine-mode and FSM-state definitions for alu_seq and the control unit.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_CMP  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_R11  = 4'd11;
    localparam logic [3:0] OP_R12  = 4'd12;
    localparam logic [3:0] OP_R13  = 4'd13;
    localparam logic [3:0] OP_R14  = 4'd14;
    localparam logic [3:0] OP_R15  = 4'd15;

    localparam int FLAG_EQ    = 0;
    localparam int FLAG_GRT   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_OVF   = 4;
    localparam int FLAG_DIVZ  = 5;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step, WIDTH steps.
// lo_nxt/hi_nxt expose the post-step values so the caller can capture the result on the final step.
module seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] count;
    logic             mode_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   diff;

    assign last = (count == CNT_W'(1));

    always_comb begin
        lo_nxt = shreg;
        hi_nxt = acc;
        sum    = '0;
        part   = '0;
        diff   = '0;
        if (mode_q == MD_DIV) begin
            // Remainder stays below the divisor, so a clear MSB of diff means part >= divisor.
            part = {acc, shreg[WIDTH-1]};
            diff = part - {1'b0, opnd};
            if (!diff[WIDTH]) begin
                hi_nxt = diff[WIDTH-1:0];
                lo_nxt = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = part[WIDTH-1:0];
                lo_nxt = {shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum    = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            shreg  <= '0;
            opnd   <= '0;
            count  <= '0;
            mode_q <= MD_MUL;
        end else if (load) begin
            acc    <= '0;
            shreg  <= a;
            opnd   <= b;
            count  <= CNT_W'(WIDTH);
            mode_q <= mode;
        end else if (step) begin
            acc    <= hi_nxt;
            shreg  <= lo_nxt;
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops report done one cycle after start, MUL/DIV after WIDTH+1 cycles.
// start is ignored while busy; all outputs are registered and hold until the next done pulse.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int FLAGS_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [FLAGS_W-1:0] flags_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   c,
    output logic [WIDTH-1:0]   c_hi,
    output logic [FLAGS_W-1:0] flags_out
);

    localparam int SH_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic               eng_load;
    logic               eng_step;
    logic               eng_last;
    logic [WIDTH-1:0]   eng_lo;
    logic [WIDTH-1:0]   eng_hi;
    logic               res_upd;
    logic               res_eng;
    logic               div_q;
    logic [FLAGS_W-1:0] flags_q;
    logic [FLAGS_W-1:0] eng_flags;

    logic [SH_W-1:0]    sh_amt;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [WIDTH-1:0]   sc_c;
    logic [WIDTH-1:0]   sc_hi;
    logic [FLAGS_W-1:0] sc_flags;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .load   (eng_load),
        .mode   ((op == OP_DIV) ? MD_DIV : MD_MUL),
        .step   (eng_step),
        .a      (a),
        .b      (b),
        .last   (eng_last),
        .lo_nxt (eng_lo),
        .hi_nxt (eng_hi)
    );

    assign busy = (state == ST_RUN);

    always_comb begin
        sh_amt   = b[SH_W-1:0];
        add_w    = {1'b0, a} + {1'b0, b};
        sub_w    = {1'b0, a} - {1'b0, b};
        // Extra bit on the shifted-out side captures the last bit lost, zero for a shift of 0.
        shl_w    = {1'b0, a} << sh_amt;
        shr_w    = {a, 1'b0} >> sh_amt;
        sc_c     = a;
        sc_hi    = '0;
        sc_flags = flags_in;
        case (op)
            OP_ADD: begin
                sc_c                 = add_w[WIDTH-1:0];
                sc_flags[FLAG_CARRY] = add_w[WIDTH];
                sc_flags[FLAG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_c                 = sub_w[WIDTH-1:0];
                sc_flags[FLAG_CARRY] = sub_w[WIDTH];
                sc_flags[FLAG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                sc_c                 = (op == OP_AND) ? (a & b) :
                                       (op == OP_OR)  ? (a | b) :
                                       (op == OP_XOR) ? (a ^ b) : ~a;
                sc_flags[FLAG_CARRY] = 1'b0;
                sc_flags[FLAG_OVF]   = 1'b0;
            end
            OP_CMP: begin
                sc_flags[FLAG_EQ]  = (a == b);
                sc_flags[FLAG_GRT] = (a > b);
            end
            OP_SHL: begin
                sc_c                 = shl_w[WIDTH-1:0];
                sc_flags[FLAG_CARRY] = shl_w[WIDTH];
            end
            OP_SHR: begin
                sc_c                 = shr_w[WIDTH:1];
                sc_flags[FLAG_CARRY] = shr_w[0];
            end
            OP_DIV: begin
                sc_c                = '1;
                sc_hi               = a;
                sc_flags[FLAG_DIVZ] = 1'b1;
                sc_flags[FLAG_ZERO] = 1'b0;
            end
            default: ;
        endcase
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR})
            sc_flags[FLAG_ZERO] = (sc_c == '0);
    end

    always_comb begin
        eng_flags = flags_q;
        if (div_q) begin
            eng_flags[FLAG_ZERO] = (eng_lo == '0);
            eng_flags[FLAG_DIVZ] = 1'b0;
        end else begin
            eng_flags[FLAG_ZERO] = ({eng_hi, eng_lo} == '0);
        end
    end

    always_comb begin
        state_nxt = state;
        eng_load  = 1'b0;
        eng_step  = 1'b0;
        res_upd   = 1'b0;
        res_eng   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                        eng_load  = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        res_upd = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                eng_step = 1'b1;
                if (eng_last) begin
                    res_upd   = 1'b1;
                    res_eng   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            c         <= '0;
            c_hi      <= '0;
            flags_out <= '0;
            flags_q   <= '0;
            div_q     <= 1'b0;
        end else begin
            done <= res_upd;
            if (res_upd) begin
                c         <= res_eng ? eng_lo    : sc_c;
                c_hi      <= res_eng ? eng_hi    : sc_hi;
                flags_out <= res_eng ? eng_flags : sc_flags;
            end
            if (eng_load) begin
                flags_q <= flags_in;
                div_q   <= (op == OP_DIV);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): arithmetic reference model plus per-cycle scoreboard, directed and random stimulus.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [7:0] flags_in = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] c;
    logic [7:0] c_hi;
    logic [7:0] flags_out;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(8), .FLAGS_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flags_in  (flags_in),
        .busy      (busy),
        .done      (done),
        .c         (c),
        .c_hi      (c_hi),
        .flags_out (flags_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: results straight from integer arithmetic on the operands.
    function automatic void ref_model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                      input logic [7:0] fi, output logic [7:0] rc, output logic [7:0] rhi,
                                      output logic [7:0] rf, output int lat);
        int ux, uy, sx, sy, r, sh;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        sh = int'(y[2:0]);
        rc = x; rhi = 8'h00; rf = fi; lat = 1;
        case (o)
            4'd0: begin
                r = ux + uy; rc = 8'(r);
                rf[2] = (r > 255); rf[4] = ((sx + sy) > 127) || ((sx + sy) < -128); rf[3] = (rc == 8'h00);
            end
            4'd1: begin
                r = ux - uy; rc = 8'(r);
                rf[2] = (r < 0); rf[4] = ((sx - sy) > 127) || ((sx - sy) < -128); rf[3] = (rc == 8'h00);
            end
            4'd2, 4'd3, 4'd4, 4'd5: begin
                rc = (o == 4'd2) ? (x & y) : (o == 4'd3) ? (x | y) : (o == 4'd4) ? (x ^ y) : ~x;
                rf[2] = 1'b0; rf[4] = 1'b0; rf[3] = (rc == 8'h00);
            end
            4'd6: begin
                rf[0] = (ux == uy); rf[1] = (ux > uy);
            end
            4'd7: begin
                r = ux * (1 << sh); rc = 8'(r);
                rf[2] = (sh != 0) && (((r >> 8) % 2) == 1); rf[3] = (rc == 8'h00);
            end
            4'd8: begin
                rc = 8'(ux >> sh);
                rf[2] = (sh != 0) && (((ux >> (sh - 1)) % 2) == 1); rf[3] = (rc == 8'h00);
            end
            4'd9: begin
                r = ux * uy; rc = 8'(r); rhi = 8'(r >> 8);
                rf[3] = (r == 0); lat = 9;
            end
            4'd10: begin
                if (uy == 0) begin
                    rc = 8'hFF; rhi = x; rf[5] = 1'b1; rf[3] = 1'b0;
                end else begin
                    rc = 8'(ux / uy); rhi = 8'(ux % uy);
                    rf[3] = ((ux / uy) == 0); rf[5] = 1'b0; lat = 9;
                end
            end
            default: ;
        endcase
    endfunction

    typedef struct {
        int         done_cyc;
        logic [7:0] c;
        logic [7:0] chi;
        logic [7:0] f;
    } exp_t;

    exp_t       pend[$];
    exp_t       e;
    int         cyc = 0;
    int         free_at = 0;
    int         busy_lo = 1;
    int         busy_hi = 0;
    int         lat;
    logic [7:0] hc = 8'h00, hchi = 8'h00, hf = 8'h00;
    logic       s_rst, s_start, exp_done;
    logic [3:0] s_op;
    logic [7:0] s_a, s_b, s_fi;

    // Scoreboard: acceptance decided from what was presented at the edge; outputs checked every cycle.
    always @(posedge clk) begin
        s_rst = rst; s_start = start; s_op = op; s_a = a; s_b = b; s_fi = flags_in;
        #2;
        cyc++;
        if (s_rst) begin
            pend.delete();
            free_at = 0; busy_lo = 1; busy_hi = 0;
            hc = 8'h00; hchi = 8'h00; hf = 8'h00;
        end else if (s_start && (cyc - 1) >= free_at) begin
            ref_model(s_op, s_a, s_b, s_fi, e.c, e.chi, e.f, lat);
            e.done_cyc = cyc - 1 + lat;
            pend.push_back(e);
            free_at = cyc - 1 + lat;
            if (lat > 1) begin
                busy_lo = cyc;
                busy_hi = cyc - 2 + lat;
            end
        end
        exp_done = 1'b0;
        if (pend.size() > 0 && pend[0].done_cyc == cyc) begin
            exp_done = 1'b1;
            hc = pend[0].c; hchi = pend[0].chi; hf = pend[0].f;
            pend.delete(0);
        end
        check("sb_done", done, exp_done);
        check("sb_busy", busy, (busy_lo <= cyc) && (cyc <= busy_hi));
        check("sb_c", c, hc);
        check("sb_c_hi", c_hi, hchi);
        check("sb_flags", flags_out, hf);
    end

    task automatic do_op(input string name, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] fi, input logic [7:0] ec, input logic [7:0] ehi,
                         input logic [7:0] ef, input int elat);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; flags_in = fi;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, done, 1);
        check({name, "_lat"}, n, elat);
        if (elat == 1) check({name, "_busy"}, busy, 0);
        check({name, "_c"}, c, ec);
        check({name, "_c_hi"}, c_hi, ehi);
        check({name, "_flags"}, flags_out, ef);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] mc, mhi, mf;
        int ml;

        // Pin the reference model to hand-computed values.
        ref_model(4'd0, 8'hF0, 8'h20, 8'h00, mc, mhi, mf, ml);
        check("model_add", {mc, mhi, mf, 8'(ml)}, 32'h10_00_04_01);
        ref_model(4'd1, 8'h80, 8'h01, 8'h00, mc, mhi, mf, ml);
        check("model_sub", {mc, mhi, mf, 8'(ml)}, 32'h7F_00_10_01);
        ref_model(4'd9, 8'd200, 8'd3, 8'h00, mc, mhi, mf, ml);
        check("model_mul", {mc, mhi, mf, 8'(ml)}, 32'h58_02_00_09);
        ref_model(4'd10, 8'd100, 8'd7, 8'h00, mc, mhi, mf, ml);
        check("model_div", {mc, mhi, mf, 8'(ml)}, 32'h0E_02_00_09);
        ref_model(4'd8, 8'h81, 8'h03, 8'h00, mc, mhi, mf, ml);
        check("model_shr", {mc, mhi, mf, 8'(ml)}, 32'h10_00_00_01);

        repeat (3) @(negedge clk);
        check("reset_c", c, 0);
        check("reset_flags", flags_out, 0);
        rst = 1'b0;

        do_op("add",  4'd0, 8'hF0, 8'h20, 8'h00, 8'h10, 8'h00, 8'h04, 1);
        do_op("sub1", 4'd1, 8'h80, 8'h01, 8'h00, 8'h7F, 8'h00, 8'h10, 1);
        do_op("sub2", 4'd1, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h04, 1);
        do_op("cmp1", 4'd6, 8'h05, 8'h05, 8'hC4, 8'h05, 8'h00, 8'hC5, 1);
        do_op("cmp2", 4'd6, 8'h09, 8'h05, 8'hC4, 8'h09, 8'h00, 8'hC6, 1);

        // MUL with an ignored start mid-run and a back-to-back DIV on the done cycle.
        @(negedge clk);
        start = 1'b1; op = 4'd9; a = 8'd200; b = 8'd3; flags_in = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 4) begin
                start = 1'b1; op = 4'd0; a = 8'h11; b = 8'h22;
            end
            if (i <= 8) begin
                check("mul_busy", busy, 1);
                check("mul_nodone", done, 0);
            end else begin
                check("mul_done", done, 1);
                check("mul_idle", busy, 0);
                check("mul_c", c, 8'h58);
                check("mul_c_hi", c_hi, 8'h02);
                check("mul_flags", flags_out, 8'h00);
                start = 1'b1; op = 4'd10; a = 8'd100; b = 8'd7; flags_in = 8'h00;
            end
        end
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 9) begin
                check("div_done", done, 1);
                check("div_c", c, 8'h0E);
                check("div_c_hi", c_hi, 8'h02);
                check("div_flags", flags_out, 8'h00);
            end else begin
                check("div_nodone", done, 0);
            end
        end

        do_op("divz", 4'd10, 8'h33, 8'h00, 8'h00, 8'hFF, 8'h33, 8'h20, 1);

        // Reset in the middle of a MUL: outputs clear at once and no done follows.
        @(negedge clk);
        start = 1'b1; op = 4'd9; a = 8'd200; b = 8'd3; flags_in = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_c", c, 0);
        check("rst_c_hi", c_hi, 0);
        check("rst_flags", flags_out, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("rst_nodone", done, 0);
        end
        do_op("shl", 4'd7, 8'h81, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 1);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 2) != 0);
            op       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 10)) : 4'($urandom_range(0, 15));
            a        = 8'($urandom);
            b        = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            flags_in = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
